// File: rtl/s_term_pkg.sv
// Shared constants and types for the south terminal tile.
// Holds the config field layout, lane counts and the routed-output bundle.
package s_term_pkg;

    localparam int CFG_W = 16;

    localparam int N1_ROT_LSB  = 0;
    localparam int N1_ROT_W    = 4;
    localparam int N2_SWAP_LSB = 4;
    localparam int N2_SWAP_W   = 8;
    localparam int N4_ROT_LSB  = 12;
    localparam int N4_ROT_W    = 2;
    localparam int CO_BIT      = 14;
    localparam int REG_EN_BIT  = 15;

    localparam int N1_LANES = 4;
    localparam int N2_LANES = 8;
    localparam int N4_LANES = 16;

    typedef struct packed {
        logic [N4_LANES-1:0] n4;
        logic [N2_LANES-1:0] n2b;
        logic [N2_LANES-1:0] n2;
        logic [N1_LANES-1:0] n1;
    } route_t;

    typedef struct packed {
        logic   co;
        route_t route;
    } oreg_t;

endpackage

// File: rtl/s_term_cfg_frame.sv
// Frame-bus config latch: owns one strobe, rejects multi-strobe writes and
// reports a sticky collision flag plus a "configured since reset" flag.
module s_term_cfg_frame
    import s_term_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 16,
    parameter int CfgFrame        = 0
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [NoConfigBits-1:0]    cfg,
    output logic                       CfgValid,
    output logic                       CfgErr
);

    // Popcount > 1 test: clearing the lowest set bit leaves something behind.
    function automatic logic multi_hot(input logic [MaxFramesPerCol-1:0] v);
        return |(v & (v - 1'b1));
    endfunction

    logic hit;
    logic collide;
    logic unused_frame_bits;

    assign hit               = FrameStrobe[CfgFrame];
    assign collide           = multi_hot(FrameStrobe);
    assign unused_frame_bits = ^FrameData[FrameBitsPerRow-1:NoConfigBits];

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            cfg      <= '0;
            CfgValid <= 1'b0;
            CfgErr   <= 1'b0;
        end else if (hit) begin
            if (collide) begin
                CfgErr <= 1'b1;
            end else begin
                cfg      <= FrameData[NoConfigBits-1:0];
                CfgValid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/s_term_single.sv
// South terminal tile: loops southbound S1/S2/S4 wires back north through a
// configurable lane mapping, drives the column carry-in, optional output register.
module s_term_single
    import s_term_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 16,
    parameter int CfgFrame        = 0
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [N1_LANES-1:0]        S1END,
    input  logic [N2_LANES-1:0]        S2MID,
    input  logic [N2_LANES-1:0]        S2END,
    input  logic [N4_LANES-1:0]        S4END,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [N1_LANES-1:0]        N1BEG,
    output logic [N2_LANES-1:0]        N2BEG,
    output logic [N2_LANES-1:0]        N2BEGb,
    output logic [N4_LANES-1:0]        N4BEG,
    output logic                       Co,
    output logic                       CfgValid,
    output logic                       CfgErr
);

    logic [CFG_W-1:0]     cfg;
    logic [N1_ROT_W-1:0]  n1_rot;
    logic [N2_SWAP_W-1:0] n2_swap;
    logic [N4_ROT_W-1:0]  n4_rot;
    logic                 co_val;
    logic                 reg_en;
    route_t               mux_out;
    oreg_t                oreg_p1;

    s_term_cfg_frame #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .FrameBitsPerRow (FrameBitsPerRow),
        .NoConfigBits    (NoConfigBits),
        .CfgFrame        (CfgFrame)
    ) u_cfg (
        .CLK         (CLK),
        .resetn      (resetn),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .cfg         (cfg),
        .CfgValid    (CfgValid),
        .CfgErr      (CfgErr)
    );

    assign n1_rot  = cfg[N1_ROT_LSB +: N1_ROT_W];
    assign n2_swap = cfg[N2_SWAP_LSB +: N2_SWAP_W];
    assign n4_rot  = cfg[N4_ROT_LSB +: N4_ROT_W];
    assign co_val  = cfg[CO_BIT];
    assign reg_en  = cfg[REG_EN_BIT];

    // A cleared cfg yields the identity mapping, which gives reset pass-through.
    always_comb begin
        mux_out = '0;
        for (int i = 0; i < N1_LANES; i++) begin
            mux_out.n1[i] = n1_rot[i] ? S1END[(i + 1) % N1_LANES] : S1END[i];
        end
        for (int i = 0; i < N2_LANES; i++) begin
            mux_out.n2[i]  = n2_swap[i] ? S2END[i] : S2MID[i];
            mux_out.n2b[i] = n2_swap[i] ? S2MID[i] : S2END[i];
        end
        for (int i = 0; i < N4_LANES; i++) begin
            logic [3:0] idx;
            idx           = 4'(i) + {n4_rot, 2'b00};
            mux_out.n4[i] = S4END[idx];
        end
    end

    // Output stage boundary: samples the live mapping every edge.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            oreg_p1 <= '0;
        end else begin
            oreg_p1 <= '{co: co_val, route: mux_out};
        end
    end

    always_comb begin
        if (reg_en) begin
            {N4BEG, N2BEGb, N2BEG, N1BEG} = oreg_p1.route;
            Co                            = oreg_p1.co;
        end else begin
            {N4BEG, N2BEGb, N2BEG, N1BEG} = mux_out;
            Co                            = co_val;
        end
    end

endmodule

// File: tb/tb_s_term_single.sv
// Self-checking bench for s_term_single: reference model from the mapping rules
// plus directed vectors with hand-computed values.
module tb_s_term_single;

    logic        CLK = 1'b0;
    logic        resetn;
    logic [3:0]  S1END;
    logic [7:0]  S2MID;
    logic [7:0]  S2END;
    logic [15:0] S4END;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic [3:0]  N1BEG;
    logic [7:0]  N2BEG;
    logic [7:0]  N2BEGb;
    logic [15:0] N4BEG;
    logic        Co;
    logic        CfgValid;
    logic        CfgErr;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    s_term_single dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .S1END       (S1END),
        .S2MID       (S2MID),
        .S2END       (S2END),
        .S4END       (S4END),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .N1BEG       (N1BEG),
        .N2BEG       (N2BEG),
        .N2BEGb      (N2BEGb),
        .N4BEG       (N4BEG),
        .Co          (Co),
        .CfgValid    (CfgValid),
        .CfgErr      (CfgErr)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [15:0] m_cfg   = '0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    logic [3:0]  r_n1    = '0;
    logic [7:0]  r_n2    = '0;
    logic [7:0]  r_n2b   = '0;
    logic [15:0] r_n4    = '0;
    logic        r_co    = 1'b0;

    function automatic logic [3:0] f_n1(logic [15:0] c, logic [3:0] s);
        logic [3:0] rot;
        rot = {s[0], s[3:1]};
        return (s & ~c[3:0]) | (rot & c[3:0]);
    endfunction

    function automatic logic [7:0] f_n2(logic [15:0] c, logic [7:0] a, logic [7:0] b);
        return (a & ~c[11:4]) | (b & c[11:4]);
    endfunction

    function automatic logic [15:0] f_n4(logic [15:0] c, logic [15:0] s);
        logic [31:0] d;
        d = {s, s} >> (4 * c[13:12]);
        return d[15:0];
    endfunction

    always @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            m_cfg = '0; m_valid = 1'b0; m_err = 1'b0;
            r_n1 = '0; r_n2 = '0; r_n2b = '0; r_n4 = '0; r_co = 1'b0;
        end else begin
            r_n1  = f_n1(m_cfg, S1END);
            r_n2  = f_n2(m_cfg, S2MID, S2END);
            r_n2b = f_n2(m_cfg, S2END, S2MID);
            r_n4  = f_n4(m_cfg, S4END);
            r_co  = m_cfg[14];
            if (FrameStrobe[0]) begin
                if ($countones(FrameStrobe) > 1) begin
                    m_err = 1'b1;
                end else begin
                    m_cfg   = FrameData[15:0];
                    m_valid = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("mdl_n1",  32'(N1BEG),  32'(m_cfg[15] ? r_n1  : f_n1(m_cfg, S1END)));
            chk("mdl_n2",  32'(N2BEG),  32'(m_cfg[15] ? r_n2  : f_n2(m_cfg, S2MID, S2END)));
            chk("mdl_n2b", 32'(N2BEGb), 32'(m_cfg[15] ? r_n2b : f_n2(m_cfg, S2END, S2MID)));
            chk("mdl_n4",  32'(N4BEG),  32'(m_cfg[15] ? r_n4  : f_n4(m_cfg, S4END)));
            chk("mdl_co",  32'(Co),     32'(m_cfg[15] ? r_co  : m_cfg[14]));
            chk("mdl_valid", 32'(CfgValid), 32'(m_valid));
            chk("mdl_err",   32'(CfgErr),   32'(m_err));
        end
    end

    task automatic wr(input logic [19:0] stb, input logic [31:0] d);
        FrameStrobe = stb;
        FrameData   = d;
        @(posedge CLK);
        #1;
        FrameStrobe = '0;
        FrameData   = '0;
    endtask

    initial begin
        resetn = 1'b1;
        S1END = 4'hA; S2MID = '0; S2END = '0; S4END = 16'h1234;
        FrameData = '0; FrameStrobe = '0;
        #1 resetn = 1'b0;
        #3;
        chk("rst_n1", 32'(N1BEG), 32'h A);
        chk("rst_n4", 32'(N4BEG), 32'h 1234);
        chk("rst_co", 32'(Co), 32'h0);
        chk("rst_valid", 32'(CfgValid), 32'h0);
        chk("rst_err", 32'(CfgErr), 32'h0);
        chk_en = 1'b1;
        @(posedge CLK); #1 resetn = 1'b1;
        @(posedge CLK); #1;

        // lanes 0,1 rotated, quad rotate by 8, carry 1
        S1END = 4'b0010;
        wr(20'h00001, 32'h0000_6003);
        #1;
        chk("wr_n1", 32'(N1BEG), 32'h1);
        chk("wr_n4", 32'(N4BEG), 32'h3412);
        chk("wr_co", 32'(Co), 32'h1);
        chk("wr_valid", 32'(CfgValid), 32'h1);

        // repeated strobe rewrites the same frame
        wr(20'h00001, 32'h0000_6003);
        wr(20'h00001, 32'h0000_6003);
        #1 chk("hold_n4", 32'(N4BEG), 32'h3412);

        // collision: strobes 0 and 5
        wr(20'h00021, 32'h0000_FFFF);
        #1;
        chk("col_n4", 32'(N4BEG), 32'h3412);
        chk("col_n1", 32'(N1BEG), 32'h1);
        chk("col_err", 32'(CfgErr), 32'h1);
        chk("col_valid", 32'(CfgValid), 32'h1);
        wr(20'h00001, 32'hFFFF_0000);
        #1;
        chk("clean_n1", 32'(N1BEG), 32'h2);
        chk("clean_co", 32'(Co), 32'h0);
        chk("clean_err", 32'(CfgErr), 32'h1);

        // registered output with full swap
        wr(20'h00001, 32'h0000_8FF0);
        #1 S2MID = 8'h55; S2END = 8'hAA;
        #1;
        chk("reg_pre_n2", 32'(N2BEG), 32'h00);
        chk("reg_pre_n2b", 32'(N2BEGb), 32'h00);
        @(posedge CLK); #1;
        chk("reg_n2", 32'(N2BEG), 32'hAA);
        chk("reg_n2b", 32'(N2BEGb), 32'h55);
        chk("reg_n1", 32'(N1BEG), 32'h2);

        // strobes not owning this tile
        wr(20'h00080, 32'h0000_0000);
        wr(20'h00088, 32'h0000_6003);
        #1;
        chk("oth_n2", 32'(N2BEG), 32'hAA);
        chk("oth_valid", 32'(CfgValid), 32'h1);
        chk("oth_err", 32'(CfgErr), 32'h1);

        // back to combinational, then async reset between edges
        wr(20'h00001, 32'h0000_6003);
        #1;
        chk("comb_co", 32'(Co), 32'h1);
        chk("comb_n2", 32'(N2BEG), 32'h55);
        @(negedge CLK); #2;
        resetn = 1'b0;
        #1;
        chk("arst_n1", 32'(N1BEG), 32'h2);
        chk("arst_n2", 32'(N2BEG), 32'h55);
        chk("arst_n2b", 32'(N2BEGb), 32'hAA);
        chk("arst_n4", 32'(N4BEG), 32'h1234);
        chk("arst_co", 32'(Co), 32'h0);
        chk("arst_valid", 32'(CfgValid), 32'h0);
        chk("arst_err", 32'(CfgErr), 32'h0);
        @(posedge CLK); #1 resetn = 1'b1;
        S4END = 16'hBEEF;
        wr(20'h00001, 32'h0000_1000);
        #1 chk("post_n4", 32'(N4BEG), 32'hFBEE);
        @(posedge CLK); #1;
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
